// File: rtl/overlap_save_framer_if.sv
// Handshake and frame bus between the sample source, the overlap-save
// framer and the downstream FFT stage.
// OS_FRAME_IDX_EN adds the 16-bit o_frame_idx signal.
interface overlap_save_framer_if #(
    parameter int unsigned NB_DATA = 16,
    parameter int unsigned N_FFT   = 32
) ();

    // Sample input side
    logic                     i_valid;
    logic                     i_enable;
    logic                     i_flush;
    logic [NB_DATA-1:0]       i_data;
    logic                     o_ready;

    // Frame output side
    logic                     i_ready;
    logic                     o_valid;
    logic [N_FFT*NB_DATA-1:0] o_frame;
`ifdef OS_FRAME_IDX_EN
    logic [15:0]              o_frame_idx;
`endif

    // Framer view
    modport slave (
        input  i_valid,
        input  i_enable,
        input  i_flush,
        input  i_data,
        output o_ready,
        input  i_ready,
        output o_valid,
`ifdef OS_FRAME_IDX_EN
        output o_frame_idx,
`endif
        output o_frame
    );

    // Source / sink view
    modport master (
        output i_valid,
        output i_enable,
        output i_flush,
        output i_data,
        input  o_ready,
        output i_ready,
        input  o_valid,
`ifdef OS_FRAME_IDX_EN
        input  o_frame_idx,
`endif
        input  o_frame
    );

endinterface

// File: rtl/overlap_save_framer.sv
// Overlap-save input framer: collects HOP = N_FFT - N_OVERLAP new samples
// per frame behind N_OVERLAP samples of history and presents the whole
// N_FFT-sample window on one flat bus with valid/ready backpressure.
// Optional macro OS_FRAME_IDX_EN adds a 16-bit retired-frame index output.
module overlap_save_framer #(
    parameter int unsigned NB_DATA   = 16,
    parameter int unsigned N_FFT     = 32,
    parameter int unsigned N_OVERLAP = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    overlap_save_framer_if.slave  bus
);

    localparam int unsigned HOP   = N_FFT - N_OVERLAP;
    localparam int unsigned CNT_W = (HOP > 1) ? $clog2(HOP) : 1;

    // Reject an overlap that leaves no room for new samples
    if (N_OVERLAP >= N_FFT) begin : g_param_check
        $error("overlap_save_framer: N_OVERLAP must be smaller than N_FFT");
    end

    typedef logic [N_FFT-1:0][NB_DATA-1:0] win_t;

    win_t             hist_q;
    win_t             hist_d;
    win_t             hist_shift;
    win_t             frame_q;
    win_t             frame_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             valid_q;
    logic             valid_d;
`ifdef OS_FRAME_IDX_EN
    logic [15:0]      idx_q;
    logic [15:0]      idx_d;
`endif

    logic cnt_last;
    logic ready_c;
    logic flush_c;
    logic acc_c;
    logic capture_c;
    logic retire_c;

    // Handshake qualifiers; only the block-completing sample can stall
    always_comb begin
        cnt_last  = (cnt_q == CNT_W'(HOP - 1));
        ready_c   = !(valid_q && !bus.i_ready && cnt_last) && !i_rst;
        // A disabled input side is fully frozen, including flush
        flush_c   = bus.i_flush && bus.i_enable;
        acc_c     = bus.i_valid && bus.i_enable && ready_c && !bus.i_flush;
        capture_c = acc_c && cnt_last;
        retire_c  = valid_q && bus.i_ready;
    end

    // History shifted one place toward index 0 with the new sample on top
    always_comb begin
        hist_shift = hist_q;
        for (int k = 0; k < int'(N_FFT) - 1; k++) begin
            hist_shift[k] = hist_q[k + 1];
        end
        hist_shift[N_FFT-1] = bus.i_data;
    end

    // Next-state for history, hop counter, frame register and valid flag
    always_comb begin
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        valid_d = valid_q;

        if (flush_c) begin
            hist_d = '0;
            cnt_d  = '0;
        end else if (acc_c) begin
            hist_d = hist_shift;
            cnt_d  = cnt_last ? '0 : cnt_q + CNT_W'(1);
        end

        // A capture on the same edge as a retire keeps o_valid high
        if (capture_c) begin
            frame_d = hist_shift;
            valid_d = 1'b1;
        end else if (retire_c) begin
            valid_d = 1'b0;
        end
    end

`ifdef OS_FRAME_IDX_EN
    // Frame index: counts retired frames, restarts with each new stream
    always_comb begin
        idx_d = idx_q;
        if (flush_c) begin
            idx_d = '0;
        end else if (retire_c) begin
            idx_d = idx_q + 16'd1;
        end
    end
`endif

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hist_q  <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
        end
    end

`ifdef OS_FRAME_IDX_EN
    // Frame index register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign bus.o_frame_idx = idx_q;
`endif

    assign bus.o_ready = ready_c;
    assign bus.o_valid = valid_q;
    assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_overlap_save_framer.sv
// Scoreboard bench for overlap_save_framer at default parameters
// (NB_DATA=16, N_FFT=32, N_OVERLAP=16).
module tb_overlap_save_framer;

    localparam int unsigned NB   = 16;
    localparam int unsigned NF   = 32;
    localparam int unsigned NO   = 16;
    localparam int unsigned FW   = NF * NB;

    typedef logic [FW-1:0] frame_t;

    logic clk;
    logic rst;

    overlap_save_framer_if #(.NB_DATA(NB), .N_FFT(NF)) bus ();

    overlap_save_framer #(
        .NB_DATA  (NB),
        .N_FFT    (NF),
        .N_OVERLAP(NO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_stall = 0;

    frame_t      exp_q[$];
    logic [15:0] exp_idx_q[$];

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Frame with NO old samples (old_start..; 0 = zero history) then NF-NO new ones
    function automatic frame_t exp_frame(input int old_start, input int new_start);
        frame_t f;
        for (int k = 0; k < int'(NF); k++) begin
            if (k < int'(NO)) f[k*NB +: NB] = (old_start == 0) ? 16'd0 : 16'(old_start + k);
            else              f[k*NB +: NB] = 16'(new_start + k - int'(NO));
        end
        return f;
    endfunction

    task automatic expect_frame(input frame_t f, input logic [15:0] idx);
        exp_q.push_back(f);
        exp_idx_q.push_back(idx);
    endtask

    // Monitor: every retire pops and checks the oldest expected frame
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame: got %h expected none", bus.o_frame);
            end else begin
                frame_t      f;
                logic [15:0] ix;
                f  = exp_q.pop_front();
                ix = exp_idx_q.pop_front();
                chk("frame", bus.o_frame, f);
`ifdef OS_FRAME_IDX_EN
                chk("frame_idx", FW'(bus.o_frame_idx), FW'(ix));
`else
                if (ix == 16'hFFFF) $display("note: unused index");
`endif
            end
        end
    end

    // Present one sample and wait (bounded) until it is accepted
    task automatic send(input logic [15:0] d);
        int w;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        w = 0;
        @(negedge clk);
        while (!bus.o_ready) begin
            w++;
            n_stall++;
            if (w > 50) begin
                n_vec++;
                n_err++;
                $display("FAIL send_timeout: sample %0d not accepted, got o_ready=0 expected 1", d);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic send_ramp(input int first, input int last);
        for (int v = first; v <= last; v++) send(16'(v));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_flush  = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_ready  = 1'b1;
        @(negedge clk);
        chk("ready_in_reset", FW'(bus.o_ready), FW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", FW'(bus.o_valid), FW'(0));
        chk("reset_frame", bus.o_frame, '0);
        chk("reset_ready", FW'(bus.o_ready), FW'(1));
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the scoreboard to empty
    task automatic drain(input string nm);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk(nm, FW'(exp_q.size()), FW'(0));
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_flush  = 1'b0;
        bus.i_data   = '0;
        bus.i_ready  = 1'b1;
        @(posedge clk);
        #1;

        // Ramp with free-flowing output, single-cycle o_valid pulse
        do_reset();
        expect_frame(exp_frame(0, 1), 16'd0);
        send_ramp(1, 16);
        @(negedge clk);
        chk("valid_after_16", FW'(bus.o_valid), FW'(1));
        @(negedge clk);
        chk("valid_pulse_end", FW'(bus.o_valid), FW'(0));
        @(posedge clk);
        #1;
        expect_frame(exp_frame(1, 17), 16'd1);
        expect_frame(exp_frame(17, 33), 16'd2);
        n_stall = 0;
        send_ramp(17, 48);
        chk("no_stall_free_flow", FW'(n_stall), FW'(0));
        drain("drain_ramp");

        // Backpressure: only the block-completing sample stalls
        do_reset();
        expect_frame(exp_frame(0, 1), 16'd0);
        send_ramp(1, 15);
        send(16'd16);
        bus.i_ready = 1'b0;
        n_stall = 0;
        send_ramp(17, 31);
        chk("early_samples_accepted", FW'(n_stall), FW'(0));
        bus.i_valid = 1'b1;
        bus.i_data  = 16'd32;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", FW'(bus.o_ready), FW'(0));
            chk("stall_valid", FW'(bus.o_valid), FW'(1));
            chk("frame_held", bus.o_frame, exp_frame(0, 1));
        end
        expect_frame(exp_frame(1, 17), 16'd1);
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", FW'(bus.o_ready), FW'(1));
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        drain("drain_backpressure");

        // Enable low freezes the input side
        do_reset();
        expect_frame(exp_frame(0, 1), 16'd0);
        send_ramp(1, 16);
        bus.i_enable = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_data   = 16'hDEAD;
        repeat (5) @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_enable = 1'b1;
        expect_frame(exp_frame(1, 17), 16'd1);
        send_ramp(17, 32);
        drain("drain_enable");

        // Flush restarts the stream with zero history
        do_reset();
        expect_frame(exp_frame(0, 1), 16'd0);
        send_ramp(1, 16);
        send_ramp(17, 21);
        bus.i_flush = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 16'hBEEF;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        expect_frame(exp_frame(0, 100), 16'd0);
        send_ramp(100, 115);
        drain("drain_flush");

        // Reset mid-block drops a pending frame and the partial block
        do_reset();
        bus.i_ready = 1'b0;
        send_ramp(1, 16);
        send_ramp(17, 26);
        @(negedge clk);
        chk("pending_before_reset", FW'(bus.o_valid), FW'(1));
        @(posedge clk);
        #1;
        do_reset();
        expect_frame(exp_frame(0, 200), 16'd0);
        send_ramp(200, 215);
        drain("drain_reset");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/overlap_save_framer.md
Name: overlap_save_framer

Overview:
Parametrised next-generation overlap-save input framer for the FFT-based filtering datapath. It takes a serial stream of complex samples, keeps the last N_OVERLAP samples of history, and builds N_FFT-sample frames of N_OVERLAP old samples plus HOP = N_FFT - N_OVERLAP new samples. Frames are presented on one flattened parallel bus to the FFT stage. New over the previous generation: a valid/ready handshake in both directions with backpressure, a stream flush, and generic N_FFT, N_OVERLAP and NB_DATA.

Parameters:
NB_DATA, 16, bits per complex sample (I and Q packed, 8+8 by default)
N_FFT, 32, frame length in samples
N_OVERLAP, 16, samples carried from one frame into the next; legal range 0..N_FFT-1

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  input sample qualifier
i_enable  input  1  global enable; low = input side frozen
i_flush  input  1  start a new stream: history cleared to zero
i_data  input  NB_DATA  input sample
o_ready  output  1  framer can accept i_data this cycle
i_ready  input  1  downstream accepts the current frame
o_valid  output  1  o_frame holds a valid frame
o_frame  output  N_FFT*NB_DATA  frame; o_frame[k*NB_DATA +: NB_DATA] = sample k; k=0 oldest, k=N_FFT-1 newest

Behaviour:
- Storage:
  - history shift register, N_FFT entries
  - frame output register, N_FFT*NB_DATA bits
  - hop counter, 0..HOP-1, width clog2(HOP), min 1 bit
- Reset (i_rst=1 at a clock edge):
  - history = 0, counter = 0, o_valid = 0, o_frame = 0
  - o_ready = 1 in the first cycle after reset
  - reset mid-frame discards the partial block and any pending frame
- Input accept: acc = i_valid & i_enable & o_ready & !i_flush. On acc:
  - history shifts one place toward index 0; i_data enters at index N_FFT-1
  - counter increments and wraps HOP-1 -> 0
- Frame capture:
  - trigger: acc with counter == HOP-1
  - o_frame is loaded with the post-shift history
  - o_valid = 1 in the next cycle (latency 1 clock from the completing sample)
- Output handshake:
  - o_valid & i_ready retires the frame; o_valid drops next cycle unless a capture occurs in the same cycle
  - capture on the same edge as a retire is allowed: o_valid stays 1 and o_frame updates
  - o_frame is stable while o_valid=1 and i_ready=0
- Backpressure: o_ready = !(o_valid & !i_ready & counter==HOP-1) & !i_rst
  - only the block-completing sample stalls; earlier samples of the next block are still accepted while the frame is pending
  - o_ready is combinational from i_ready
- i_enable=0:
  - no accept; history and counter hold
  - output handshake keeps working
- i_flush=1 (priority over i_valid; that cycle's sample is dropped):
  - history = 0, counter = 0
  - a pending o_valid frame is kept until retired
- First frame after reset or flush: samples 0..N_OVERLAP-1 = 0.
- N_OVERLAP=0: every frame holds N_FFT fresh samples.
- Elaboration: N_OVERLAP >= N_FFT gives a $error / fatal.

Optional Feature:
Macro OS_FRAME_IDX_EN.
- Defined: adds output o_frame_idx, 16 bits.
  - cleared by reset and by flush
  - increments, with wrap, on every frame retire
  - during o_valid it carries the index of the frame currently on o_frame; first frame = 0
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Default parameters, reset, ramp 1..16 with i_valid=1, i_ready=1 -> o_valid one cycle after sample 16; samples 0..15 = 0, samples 16..31 = 1..16; single-cycle o_valid pulse.
- Continue with ramp 17..48 -> frame 2 = [1..32], frame 3 = [17..48]; o_ready stays 1 throughout.
- After frame 1, i_ready=0, stream 17..32 -> samples 17..31 accepted, o_ready=0 while sample 32 is presented; frame 1 held unchanged. Raise i_ready -> frame 1 retires, 32 accepted, frame 2 = [1..32] one cycle later.
- After frame 1, i_enable=0 for 5 cycles with i_valid=1 and data 0xDEAD -> no shifts, counter holds. Resume with 17..32 -> frame 2 = [1..32], no 0xDEAD anywhere.
- After frame 1, send 17..21, pulse i_flush, send 100..115 -> next frame samples 0..15 = 0, samples 16..31 = 100..115.
- Assert i_rst after 10 samples of a block -> o_valid=0 and o_frame=0; next 16 samples give a frame with zero history. With OS_FRAME_IDX_EN defined, o_frame_idx = 0, 1, 2 on successive frames and returns to 0 after reset or flush.
